change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream stage of the vending machine controller. It consumes the change/refund amount the controller issues (cng with pdt on a sale, rtn on a cancel) as a single request. It pays that amount out of two coin tubes, value-2 and value-1, by driving the coin ejectors one coin at a time with an ack handshake. It keeps per-tube stock counts and reports any shortfall or ejector fault.

Parameters:
AMT_W, 3, width of the requested amount (matches cng/rtn).
CNT_W, 6, width of each tube stock counter.
TUBE1_INIT, 20, value-1 tube count after reset.
TUBE2_INIT, 20, value-2 tube count after reset.
ACK_TIMEOUT, 15, maximum cycles in EJECT without ej_ack before fault.
EJECT_GAP, 2, minimum cycles between consecutive ejections.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  change/refund request; held until accepted.
req_amt  in  AMT_W  amount to pay, in units.
req_ready  out  1  high only in IDLE.
ej1  out  1  value-1 ejector drive.
ej2  out  1  value-2 ejector drive.
ej_ack  in  1  ejector reports coin released.
refill1  in  1  add one coin to tube1 on each cycle it is high.
refill2  in  1  add one coin to tube2 on each cycle it is high.
clr_err  in  1  leave FAULT.
done  out  1  one-cycle pulse when a request completes.
short_amt  out  AMT_W  unpaid remainder; valid with done, held until the next done.
err_timeout  out  1  sticky fault flag.
tube1_cnt  out  CNT_W  value-1 stock.
tube2_cnt  out  CNT_W  value-2 stock.
tube1_empty  out  1  tube1_cnt==0.
tube2_empty  out  1  tube2_cnt==0.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE.
  - ej1=ej2=0, done=0, short_amt=0, err_timeout=0.
  - Tube counters set to TUBE1_INIT and TUBE2_INIT; remain=0; timer=0.
- Outputs are Moore decodes of registered state:
  - ej1 or ej2 is high only in EJECT; never both.
  - req_ready = (state==IDLE).
- States and transitions:
  - IDLE: on req_valid&&req_ready, latch remain=req_amt and go to SELECT.
  - SELECT, one cycle, choose in order:
    - remain==0: go to DONE.
    - remain>=2 and tube2_cnt>0: coin=2, go to EJECT.
    - remain>=1 and tube1_cnt>0: coin=1, go to EJECT. Value-1 coins cover a value-2 need when tube2 is empty.
    - otherwise: go to DONE.
  - EJECT: drive the selected ejector and count cycles in timer.
    - ej_ack sampled high: decrement that tube, remain-=coin, clear timer, go to GAP.
    - timer==ACK_TIMEOUT-1 with no ack: set err_timeout, go to FAULT. No decrement.
  - GAP: wait at least EJECT_GAP cycles AND until ej_ack==0, then go to SELECT.
  - DONE: done=1 for this cycle; short_amt=remain; next state IDLE.
  - FAULT: ejectors off, req_ready=0.
    - On clr_err=1: clear err_timeout, short_amt=remain, pulse done, go to IDLE.
- Latency, amount 1 with immediate ack: accept at edge N, SELECT at N+1, EJECT at N+2 (ej high), GAP at N+3 … DONE.
- Boundary rules:
  - req_amt==0: IDLE→SELECT→DONE, short_amt=0.
  - Tube counters saturate at 0 and at 2^CNT_W-1.
  - refill and decrement on the same tube in the same cycle: net count unchanged.
  - ej_ack outside EJECT is ignored.
  - req_valid outside IDLE is not accepted; the requester holds it.
  - Reset mid-EJECT: ejector drops immediately (async); the in-flight coin is not counted.
- Arithmetic: remain is AMT_W bits and never underflows, because coin<=remain is guaranteed by SELECT.

Decomposition:
- Package vm_change_pkg holds: state enum (IDLE, SELECT, EJECT, GAP, DONE, FAULT), COIN1_VAL=1, COIN2_VAL=2.
- Sub-module tube_counter: saturating up/down counter with init value, inc, dec, cnt and empty. Instantiated twice.

Test Plan:
- Tubes 20/20, req_amt=5, ack 1 cycle after each ej → ej2, ej2, ej1 in order; tube2=18, tube1=19; done with short_amt=0.
- tube2=0, tube1=20, req_amt=3 → three ej1 pulses; tube1=17; short_amt=0.
- tube1=0, tube2=1, req_amt=3 → one ej2; done with short_amt=1; tube2_empty=1.
- req_amt=2, ej_ack never asserted → err_timeout=1 after 15 EJECT cycles, tube2 unchanged. clr_err → done with short_amt=2, req_ready=1.
- refill1 pulsed the same cycle as an ej1 ack → tube1_cnt unchanged. refill2 held 70 cycles from 20 → tube2_cnt=63 (saturated).
- Reset asserted during EJECT → ej1=ej2=0 immediately; after release, counts equal TUBE1_INIT/TUBE2_INIT and req_ready=1.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// vm_change_pkg: shared state encoding and coin values for the change dispenser.
package vm_change_pkg;
   typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE, FAULT} state_t;
   localparam int COIN1_VAL = 1;
   localparam int COIN2_VAL = 2;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/completion handshake and coin-ejector handshake.
interface change_dispenser_if #(parameter int AMT_W = 3);
   logic req_valid, req_ready, ej1, ej2, ej_ack, done;
   logic [AMT_W-1:0] req_amt, short_amt;
   modport master(output req_valid, req_amt, ej_ack, input req_ready, ej1, ej2, done, short_amt);
   modport slave(input req_valid, req_amt, ej_ack, output req_ready, ej1, ej2, done, short_amt);
endinterface

// File: rtl/change_dispenser_tube_counter.sv
// tube_counter: saturating coin-stock counter; simultaneous inc and dec cancel out.
module tube_counter #(
   parameter int CNT_W = 6,
   parameter int INIT  = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             empty
);
   localparam logic [CNT_W-1:0] MAX = '1;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= CNT_W'(INIT);
      else if (inc && !dec && cnt != MAX) cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && cnt != '0) cnt <= cnt - CNT_W'(1);
   assign empty = cnt == '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount from value-2 and value-1 tubes one coin at a time.
module change_dispenser
   import vm_change_pkg::*;
#(
   parameter int AMT_W       = 3,
   parameter int CNT_W       = 6,
   parameter int TUBE1_INIT  = 20,
   parameter int TUBE2_INIT  = 20,
   parameter int ACK_TIMEOUT = 15,
   parameter int EJECT_GAP   = 2
) (
   input  logic                clk,
   input  logic                rst,
   change_dispenser_if.slave   bus,
   input  logic                refill1,
   input  logic                refill2,
   input  logic                clr_err,
   output logic                err_timeout,
   output logic [CNT_W-1:0]    tube1_cnt,
   output logic [CNT_W-1:0]    tube2_cnt,
   output logic                tube1_empty,
   output logic                tube2_empty
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [AMT_W-1:0] C1 = AMT_W'(COIN1_VAL);
   localparam logic [AMT_W-1:0] C2 = AMT_W'(COIN2_VAL);
   state_t           state;
   logic [AMT_W-1:0] remain;
   logic [TW-1:0]    timer;
   logic             coin2;
   logic             ack_hit, take2, take1;
   assign ack_hit = state == EJECT && bus.ej_ack;
   // Value-1 coins also cover a value-2 need once tube2 runs dry.
   assign take2 = remain >= C2 && !tube2_empty;
   assign take1 = remain != '0 && !tube1_empty;
   assign bus.req_ready = state == IDLE;
   tube_counter #(.CNT_W(CNT_W), .INIT(TUBE1_INIT)) u_tube1 (
      .clk(clk), .rst(rst), .inc(refill1), .dec(ack_hit && !coin2),
      .cnt(tube1_cnt), .empty(tube1_empty)
   );
   tube_counter #(.CNT_W(CNT_W), .INIT(TUBE2_INIT)) u_tube2 (
      .clk(clk), .rst(rst), .inc(refill2), .dec(ack_hit && coin2),
      .cnt(tube2_cnt), .empty(tube2_empty)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state         <= IDLE;
         remain        <= '0;
         timer         <= '0;
         coin2         <= 1'b0;
         bus.ej1       <= 1'b0;
         bus.ej2       <= 1'b0;
         bus.done      <= 1'b0;
         bus.short_amt <= '0;
         err_timeout   <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               remain <= bus.req_amt;
               state  <= SELECT;
            end
            SELECT: if (take2 || take1) begin
               coin2   <= take2;
               bus.ej2 <= take2;
               bus.ej1 <= !take2;
               timer   <= '0;
               state   <= EJECT;
            end else begin
               bus.done      <= 1'b1;
               bus.short_amt <= remain;
               state         <= DONE;
            end
            EJECT: if (bus.ej_ack) begin
               remain  <= remain - (coin2 ? C2 : C1);
               timer   <= '0;
               bus.ej1 <= 1'b0;
               bus.ej2 <= 1'b0;
               state   <= GAP;
            end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               err_timeout <= 1'b1;
               bus.ej1     <= 1'b0;
               bus.ej2     <= 1'b0;
               state       <= FAULT;
            end else timer <= timer + TW'(1);
            // Hold off until the minimum gap has elapsed and the ejector has released ack.
            GAP: if (timer == TW'(EJECT_GAP - 1)) begin
               if (!bus.ej_ack) state <= SELECT;
            end else timer <= timer + TW'(1);
            DONE: state <= IDLE;
            FAULT: if (clr_err) begin
               err_timeout   <= 1'b0;
               bus.short_amt <= remain;
               bus.done      <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized requests checked against a greedy coin-payout model.
module tb_change_dispenser;
   logic clk = 0, rst = 0, clr_err = 0;
   logic r1_main = 0, r1_resp = 0, refill2 = 0;
   logic refill1, err_timeout, tube1_empty, tube2_empty;
   logic [5:0] tube1_cnt, tube2_cnt;
   int nvec = 0, nerr = 0, m1 = 20, m2 = 20, both_cnt = 0;
   int obs[$];
   bit ack_en = 1, ref_on_ack = 0, noise = 0;
   change_dispenser_if #(.AMT_W(3)) bus ();
   assign refill1 = r1_main | r1_resp;
   change_dispenser dut (
      .clk(clk), .rst(rst), .bus(bus), .refill1(refill1), .refill2(refill2), .clr_err(clr_err),
      .err_timeout(err_timeout), .tube1_cnt(tube1_cnt), .tube2_cnt(tube2_cnt),
      .tube1_empty(tube1_empty), .tube2_empty(tube2_empty)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   initial begin
      bus.ej_ack = 0;
      forever begin
         @(negedge clk);
         if ((bus.ej1 || bus.ej2) && ack_en) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            obs.push_back(bus.ej2 ? 2 : 1);
            r1_resp = ref_on_ack && bus.ej1;
            bus.ej_ack = 1;
            @(negedge clk);
            bus.ej_ack = 0;
            r1_resp = 0;
         end else bus.ej_ack = noise ? 1'($urandom) : 1'b0;
      end
   end
   initial forever begin
      @(negedge clk);
      if (bus.ej1 && bus.ej2) both_cnt++;
   end
   task automatic refill(input int which, input int n, input bit nz = 0);
      @(negedge clk);
      r1_main = which[0];
      refill2 = which[1];
      noise = nz;
      repeat (n) @(negedge clk);
      r1_main = 0;
      refill2 = 0;
      noise = 0;
      if (which[0]) m1 = (m1 + n > 63) ? 63 : m1 + n;
      if (which[1]) m2 = (m2 + n > 63) ? 63 : m2 + n;
   endtask
   task automatic do_req(input int amt, input bit ref1 = 0);
      int r, k;
      int exp_q[$];
      r = amt;
      while (r > 0) begin
         if (r >= 2 && m2 > 0) begin exp_q.push_back(2); m2--; r -= 2; end
         else if (m1 > 0) begin exp_q.push_back(1); if (!ref1) m1--; r -= 1; end
         else break;
      end
      obs.delete();
      ref_on_ack = ref1;
      @(negedge clk);
      check("ready_idle", bus.req_ready, 1);
      bus.req_valid = 1;
      bus.req_amt = 3'(amt);
      @(posedge clk);
      #1 bus.req_valid = 0;
      k = 0;
      while (!bus.done && k < 300) begin @(negedge clk); k++; end
      check("done_seen", k < 300, 1);
      check("short_amt", bus.short_amt, r);
      check("ncoins", obs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) check("coin", obs[i], exp_q[i]);
      check("tube1", tube1_cnt, m1);
      check("tube2", tube2_cnt, m2);
      check("empty1", tube1_empty, m1 == 0);
      check("empty2", tube2_empty, m2 == 0);
      @(negedge clk);
      check("done_pulse", bus.done, 0);
      ref_on_ack = 0;
   endtask
   initial begin
      int k, cnt;
      bus.req_valid = 0;
      bus.req_amt = 0;
      #12;
      check("rst_ready", bus.req_ready, 1);
      check("rst_ej", {bus.ej1, bus.ej2}, 0);
      check("rst_done", bus.done, 0);
      check("rst_short", bus.short_amt, 0);
      check("rst_err", err_timeout, 0);
      check("rst_t1", tube1_cnt, 20);
      check("rst_t2", tube2_cnt, 20);
      @(negedge clk) rst = 1;
      do_req(5);
      check("t5_tube2", tube2_cnt, 18);
      check("t5_tube1", tube1_cnt, 19);
      while (m2 > 0) do_req(2);
      do_req(3);
      check("t2e_tube1", tube1_cnt, 16);
      while (m1 > 0) do_req(7);
      refill(2, 1);
      do_req(3);
      check("short1_t2e", tube2_empty, 1);
      refill(1, 5);
      do_req(1, 1);
      check("refill_dec", tube1_cnt, 5);
      refill(2, 70);
      check("sat63", tube2_cnt, 63);
      ack_en = 0;
      @(negedge clk);
      bus.req_valid = 1;
      bus.req_amt = 3'd2;
      @(posedge clk);
      #1 bus.req_valid = 0;
      k = 0;
      cnt = 0;
      while (!err_timeout && k < 100) begin
         @(negedge clk);
         if (bus.ej2) cnt++;
         k++;
      end
      check("to_cycles", cnt, 15);
      check("to_err", err_timeout, 1);
      check("to_ej", {bus.ej1, bus.ej2}, 0);
      check("to_ready", bus.req_ready, 0);
      check("to_tube2", tube2_cnt, m2);
      clr_err = 1;
      @(negedge clk);
      clr_err = 0;
      check("clr_done", bus.done, 1);
      check("clr_short", bus.short_amt, 2);
      check("clr_err", err_timeout, 0);
      check("clr_ready", bus.req_ready, 1);
      ack_en = 1;
      repeat (25) begin
         if ($urandom_range(0, 3) == 0) refill($urandom_range(1, 3), $urandom_range(1, 6), 1);
         do_req($urandom_range(0, 7));
      end
      ack_en = 0;
      @(negedge clk);
      bus.req_valid = 1;
      bus.req_amt = 3'd1;
      @(posedge clk);
      #1 bus.req_valid = 0;
      @(negedge clk);
      check("lat_select", bus.ej1, 0);
      @(negedge clk);
      check("lat_eject", bus.ej1 | bus.ej2, 1);
      #2 rst = 0;
      #1 check("arst_ej", {bus.ej1, bus.ej2}, 0);
      @(negedge clk) rst = 1;
      m1 = 20;
      m2 = 20;
      #1 check("arst_t1", tube1_cnt, 20);
      check("arst_t2", tube2_cnt, 20);
      check("arst_ready", bus.req_ready, 1);
      ack_en = 1;
      do_req(4);
      check("ej_excl", both_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
